// File: rtl/video_sync_gen_pkg.sv
// ============================================================================
// Module   : video_timing_pkg
// Brief    : Raster timing descriptor, derived-position helper and defaults.
// Revision : 1.0
// ============================================================================
`default_nettype none

package video_timing_pkg;

    typedef struct packed {
        int unsigned active;
        int unsigned fp;
        int unsigned sync;
        int unsigned bp;
    } timing_t;

    typedef struct packed {
        int unsigned total;
        int unsigned sync_start;
        int unsigned sync_end;
    } timing_derived_t;

    localparam timing_t c_h_default = '{active: 320, fp: 16, sync: 32, bp: 32};
    localparam timing_t c_v_default = '{active: 240, fp: 4,  sync: 3,  bp: 15};

    function automatic timing_derived_t derive_timing(input timing_t t);
        timing_derived_t d;
        d.sync_start = t.active + t.fp;
        d.sync_end   = d.sync_start + t.sync - 1;
        d.total      = d.sync_start + t.sync + t.bp;
        return d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/video_sync_gen_sync_axis_counter.sv
// ============================================================================
// Module   : sync_axis_counter
// Brief    : One raster axis: position counter with registered blank and sync.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_axis_counter
    import video_timing_pkg::*;
#(
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_upd,
    input  logic             i_adv,
    input  logic             i_sync_stb,
    input  timing_t          i_timing,
    output logic [CNT_W-1:0] o_count,
    output logic             o_wrap,
    output logic             o_sync_start,
    output logic             o_blank,
    output logic             o_sync
);

    timing_derived_t  w_derived;
    logic [CNT_W-1:0] w_last;
    logic [CNT_W-1:0] w_active;
    logic [CNT_W-1:0] w_sync_first;
    logic [CNT_W-1:0] w_sync_last;
    logic [CNT_W-1:0] w_next;
    logic             w_wrap;

    logic [CNT_W-1:0] r_count;
    logic             r_blank;
    logic             r_sync;

    always_comb begin
        w_derived    = derive_timing(i_timing);
        w_last       = CNT_W'(w_derived.total - 1);
        w_active     = CNT_W'(i_timing.active);
        w_sync_first = CNT_W'(w_derived.sync_start);
        w_sync_last  = CNT_W'(w_derived.sync_end);
        w_wrap       = i_adv && (r_count == w_last);
        if (!i_adv) begin
            w_next = r_count;
        end else if (w_wrap) begin
            w_next = '0;
        end else begin
            w_next = r_count + CNT_W'(1);
        end
    end

    // Sync only re-evaluates on its edge strobe so it can be aligned to another axis.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_blank <= 1'b1;
            r_sync  <= 1'b0;
        end else if (i_upd) begin
            r_count <= w_next;
            r_blank <= (w_next >= w_active);
            if (i_sync_stb) begin
                r_sync <= (w_next >= w_sync_first) && (w_next <= w_sync_last);
            end
        end
    end

    assign o_count      = r_count;
    assign o_wrap       = w_wrap;
    assign o_sync_start = i_upd && (w_next == w_sync_first);
    assign o_blank      = r_blank;
    assign o_sync       = r_sync;

endmodule

`default_nettype wire

// File: rtl/video_sync_gen.sv
// ============================================================================
// Module   : video_sync_gen
// Brief    : Raster sync/blank/DE/coordinate generator on a pixel clock enable.
// Revision : 1.0
// ============================================================================
`default_nettype none

module video_sync_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = int'(c_h_default.active),
    parameter int H_FP     = int'(c_h_default.fp),
    parameter int H_SYNC   = int'(c_h_default.sync),
    parameter int H_BP     = int'(c_h_default.bp),
    parameter int V_ACTIVE = int'(c_v_default.active),
    parameter int V_FP     = int'(c_v_default.fp),
    parameter int V_SYNC   = int'(c_v_default.sync),
    parameter int V_BP     = int'(c_v_default.bp),
    parameter int HS_POL   = 1,
    parameter int VS_POL   = 1,
    parameter int CNT_W    = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce_pix,
    output logic             hsync,
    output logic             vsync,
    output logic             hblank,
    output logic             vblank,
    output logic             de,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             frame_start,
    output logic             line_start
);

    localparam timing_t c_h_timing = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
    localparam timing_t c_v_timing = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};
    localparam longint  c_h_total  = longint'(H_ACTIVE) + H_FP + H_SYNC + H_BP;
    localparam longint  c_v_total  = longint'(V_ACTIVE) + V_FP + V_SYNC + V_BP;
    localparam longint  c_limit    = longint'(1) << CNT_W;

    generate
        if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
            V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
            HS_POL < 0 || HS_POL > 1 || VS_POL < 0 || VS_POL > 1 || CNT_W < 1 ||
            c_h_total > c_limit || c_v_total > c_limit) begin : g_param_check
            $fatal(1, "video_sync_gen: illegal timing parameters");
        end
    endgenerate

    logic             r_running;
    logic             r_frame_start;
    logic             r_line_start;

    logic             w_h_adv;
    logic             w_h_wrap;
    logic             w_h_sync_start;
    logic             w_h_blank;
    logic             w_h_sync;
    logic             w_v_wrap;
    logic             w_v_sync_start_unused;
    logic             w_v_blank;
    logic             w_v_sync;
    logic             w_line_enter;
    logic             w_frame_enter;

    // The first enabled update after reset presents (0,0) instead of advancing past it.
    assign w_h_adv       = ce_pix & r_running;
    assign w_line_enter  = ce_pix & (w_h_wrap | ~r_running);
    assign w_frame_enter = w_line_enter & (w_v_wrap | ~r_running);

    sync_axis_counter #(
        .CNT_W        (CNT_W)
    ) u_h_axis (
        .clk          (clk),
        .rst          (reset),
        .i_upd        (ce_pix),
        .i_adv        (w_h_adv),
        .i_sync_stb   (1'b1),
        .i_timing     (c_h_timing),
        .o_count      (x),
        .o_wrap       (w_h_wrap),
        .o_sync_start (w_h_sync_start),
        .o_blank      (w_h_blank),
        .o_sync       (w_h_sync)
    );

    // Vertical sync edges ride on the hsync leading edge, not on line start.
    sync_axis_counter #(
        .CNT_W        (CNT_W)
    ) u_v_axis (
        .clk          (clk),
        .rst          (reset),
        .i_upd        (ce_pix),
        .i_adv        (w_h_wrap),
        .i_sync_stb   (w_h_sync_start),
        .i_timing     (c_v_timing),
        .o_count      (y),
        .o_wrap       (w_v_wrap),
        .o_sync_start (w_v_sync_start_unused),
        .o_blank      (w_v_blank),
        .o_sync       (w_v_sync)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_running     <= 1'b0;
            r_frame_start <= 1'b0;
            r_line_start  <= 1'b0;
        end else begin
            r_frame_start <= w_frame_enter;
            r_line_start  <= w_line_enter;
            if (ce_pix) begin
                r_running <= 1'b1;
            end
        end
    end

    assign hsync       = (HS_POL != 0) ? w_h_sync : ~w_h_sync;
    assign vsync       = (VS_POL != 0) ? w_v_sync : ~w_v_sync;
    assign hblank      = w_h_blank;
    assign vblank      = w_v_blank;
    assign de          = ~w_h_blank & ~w_v_blank;
    assign frame_start = r_frame_start;
    assign line_start  = r_line_start;

endmodule

`default_nettype wire

// File: tb/tb_video_sync_gen.sv
// ============================================================================
// Module   : tb_video_sync_gen
// Brief    : Self-checking bench for video_sync_gen against a raster-position model.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_video_sync_gen;

    localparam int ND = 4;
    // 0: defaults, 1: tiny raster, 2: default H with short frame, 3: as 2 with inverted sync
    localparam int C_HA [ND] = '{320, 4, 320, 320};
    localparam int C_HF [ND] = '{16,  1, 16,  16};
    localparam int C_HS [ND] = '{32,  1, 32,  32};
    localparam int C_HB [ND] = '{32,  1, 32,  32};
    localparam int C_VA [ND] = '{240, 2, 8,   8};
    localparam int C_VF [ND] = '{4,   1, 4,   4};
    localparam int C_VS [ND] = '{3,   1, 3,   3};
    localparam int C_VB [ND] = '{15,  1, 15,  15};
    localparam int C_HP [ND] = '{1,   1, 1,   0};
    localparam int C_VP [ND] = '{1,   1, 1,   0};

    logic clk    = 1'b0;
    logic reset  = 1'b1;
    logic ce_pix = 1'b0;

    logic        hs [ND];
    logic        vs [ND];
    logic        hb [ND];
    logic        vb [ND];
    logic        de [ND];
    logic        fs [ND];
    logic        ls [ND];
    logic [11:0] xo [ND];
    logic [11:0] yo [ND];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < ND; g++) begin : g_dut
            video_sync_gen #(
                .H_ACTIVE (C_HA[g]), .H_FP (C_HF[g]), .H_SYNC (C_HS[g]), .H_BP (C_HB[g]),
                .V_ACTIVE (C_VA[g]), .V_FP (C_VF[g]), .V_SYNC (C_VS[g]), .V_BP (C_VB[g]),
                .HS_POL   (C_HP[g]), .VS_POL (C_VP[g]), .CNT_W (12)
            ) u_dut (
                .clk         (clk),
                .reset       (reset),
                .ce_pix      (ce_pix),
                .hsync       (hs[g]),
                .vsync       (vs[g]),
                .hblank      (hb[g]),
                .vblank      (vb[g]),
                .de          (de[g]),
                .x           (xo[g]),
                .y           (yo[g]),
                .frame_start (fs[g]),
                .line_start  (ls[g])
            );
        end
    endgenerate

    // ---------------- reference model: raster position and region rules ----------------
    function automatic int h_total(int d);
        return C_HA[d] + C_HF[d] + C_HS[d] + C_HB[d];
    endfunction

    function automatic int v_total(int d);
        return C_VA[d] + C_VF[d] + C_VS[d] + C_VB[d];
    endfunction

    function automatic logic [30:0] reset_vec(int d);
        return {logic'(C_HP[d] == 0), logic'(C_VP[d] == 0), 5'b11000, 24'd0};
    endfunction

    function automatic logic [30:0] model_vec(int d, int px, int py, bit pulse);
        int  ht    = h_total(d);
        int  hs0   = C_HA[d] + C_HF[d];
        int  vs0   = C_VA[d] + C_VF[d];
        int  pos   = py * ht + px;
        bit  h_on  = (px >= hs0) && (px < hs0 + C_HS[d]);
        bit  v_on  = (pos >= vs0 * ht + hs0) && (pos < (vs0 + C_VS[d]) * ht + hs0);
        bit  h_bl  = (px >= C_HA[d]);
        bit  v_bl  = (py >= C_VA[d]);
        logic [11:0] xv = 12'(px);
        logic [11:0] yv = 12'(py);
        return {logic'(h_on == (C_HP[d] != 0)), logic'(v_on == (C_VP[d] != 0)),
                logic'(h_bl), logic'(v_bl), logic'(!h_bl && !v_bl),
                logic'(pulse && px == 0 && py == 0), logic'(pulse && px == 0), xv, yv};
    endfunction

    function automatic logic [30:0] got_vec(int d);
        return {hs[d], vs[d], hb[d], vb[d], de[d], fs[d], ls[d], xo[d], yo[d]};
    endfunction

    int          mx     [ND];
    int          my     [ND];
    bit          mstart [ND];
    logic [30:0] mexp   [ND];

    always @(posedge clk) begin
        for (int d = 0; d < ND; d++) begin
            int nx, ny;
            bit ns;
            nx = mx[d];
            ny = my[d];
            ns = mstart[d];
            if (reset) begin
                nx = 0; ny = 0; ns = 0;
            end else if (ce_pix) begin
                if (ns) begin
                    nx = nx + 1;
                    if (nx == h_total(d)) begin
                        nx = 0;
                        ny = ny + 1;
                        if (ny == v_total(d)) ny = 0;
                    end
                end
                ns = 1;
            end
            mx[d]     <= nx;
            my[d]     <= ny;
            mstart[d] <= ns;
            mexp[d]   <= ns ? model_vec(d, nx, ny, !reset && ce_pix) : reset_vec(d);
        end
    end

    // Every-cycle comparison of all instances against the model, tallied per task.
    bit          ls_en  = 0;
    int          ls_bad = 0;
    int          ls_dut = 0;
    logic [30:0] ls_got = '0;
    logic [30:0] ls_exp = '0;

    always @(negedge clk) begin
        if (ls_en) begin
            for (int d = 0; d < ND; d++) begin
                if (got_vec(d) !== mexp[d]) begin
                    ls_bad = ls_bad + 1;
                    ls_dut = d;
                    ls_got = got_vec(d);
                    ls_exp = mexp[d];
                end
            end
        end
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int          base;
        logic [30:0] rv = {7'b0011000, 24'd0};
        reset  = 1'b1;
        ce_pix = 1'b1;
        repeat (3) @(negedge clk);
        ls_en = 1;
        base  = ls_bad;
        n_vec++;
        if (got_vec(0) !== rv) begin
            n_err++;
            $display("FAIL reset_values: got %h expected %h", got_vec(0), rv);
        end
        n_vec++;
        if ({hs[3], vs[3]} !== 2'b11) begin
            n_err++;
            $display("FAIL reset_inverted_sync: got %b expected 11", {hs[3], vs[3]});
        end
        reset  = 1'b0;
        ce_pix = 1'b0;
        repeat (4) @(negedge clk);
        n_vec++;
        if (got_vec(0) !== rv) begin
            n_err++;
            $display("FAIL hold_before_enable: got %h expected %h", got_vec(0), rv);
        end
        n_vec++;
        if (ls_bad != base) begin
            n_err++;
            $display("FAIL lockstep_reset: %0d bad cycles, dut%0d got %h expected %h", ls_bad - base, ls_dut, ls_got, ls_exp);
        end
    endtask

    task automatic test_full_rate();
        int   base = ls_bad;
        int   last_ls = -1, last_f1 = -1, last_f2 = -1;
        int   hs_run = 0, vs_run = 0, de_cnt = 0, xmax = 0, ymax = 0;
        int   n_hrise = 0, n_line = 0, n_vrise = 0, n_vfall = 0, n_f1 = 0, n_f2 = 0;
        int   b_hstart = 0, b_hwidth = 0, b_line = 0, b_vrise = 0, b_vfall = 0;
        int   b_vwidth = 0, b_f1 = 0, b_f2 = 0, b_de = 0;
        logic p_hs0 = 1'b0, p_hs2 = 1'b0, p_vs2 = 1'b0;
        bit   h2_rise;
        ce_pix = 1'b1;
        for (int cyc = 0; cyc < 24100; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                n_vec++;
                if ({xo[0], yo[0], fs[0], ls[0], hb[0]} !== {12'd0, 12'd0, 3'b110}) begin
                    n_err++;
                    $display("FAIL first_update: x=%0d y=%0d fs=%b ls=%b hblank=%b expected 0 0 1 1 0",
                             xo[0], yo[0], fs[0], ls[0], hb[0]);
                end
            end
            if (hs[0] && !p_hs0) begin
                n_hrise++;
                if (xo[0] != 12'd336) b_hstart++;
                hs_run = 0;
            end
            if (hs[0]) hs_run++;
            if (!hs[0] && p_hs0 && hs_run != 32) b_hwidth++;
            if (ls[0]) begin
                if (last_ls >= 0) begin
                    n_line++;
                    if (cyc - last_ls != 400) b_line++;
                end
                last_ls = cyc;
            end
            h2_rise = hs[2] && !p_hs2;
            if (vs[2] && !p_vs2) begin
                n_vrise++;
                if (!h2_rise || yo[2] != 12'd12 || xo[2] != 12'd336) b_vrise++;
                vs_run = 0;
            end
            if (vs[2]) vs_run++;
            if (!vs[2] && p_vs2) begin
                n_vfall++;
                if (!h2_rise || yo[2] != 12'd15 || xo[2] != 12'd336) b_vfall++;
                if (vs_run != 1200) b_vwidth++;
            end
            if (fs[2]) begin
                if (last_f2 >= 0) begin
                    n_f2++;
                    if (cyc - last_f2 != 12000) b_f2++;
                end
                last_f2 = cyc;
            end
            if (fs[1]) begin
                if (last_f1 >= 0) begin
                    n_f1++;
                    if (cyc - last_f1 != 35) b_f1++;
                    if (de_cnt != 8) b_de++;
                end
                last_f1 = cyc;
                de_cnt  = 0;
            end
            if (de[1]) de_cnt++;
            if (int'(xo[1]) > xmax) xmax = int'(xo[1]);
            if (int'(yo[1]) > ymax) ymax = int'(yo[1]);
            p_hs0 = hs[0];
            p_hs2 = hs[2];
            p_vs2 = vs[2];
        end
        n_vec++;
        if (b_hstart != 0 || n_hrise < 50) begin
            n_err++;
            $display("FAIL hsync_start: %0d rises, %0d not at x=336 (need >=50 rises, 0 bad)", n_hrise, b_hstart);
        end
        n_vec++;
        if (b_hwidth != 0) begin
            n_err++;
            $display("FAIL hsync_width: %0d pulses not 32 clks wide, required 0", b_hwidth);
        end
        n_vec++;
        if (b_line != 0 || n_line < 50) begin
            n_err++;
            $display("FAIL line_period: %0d periods, %0d not 400 clks (need >=50, 0 bad)", n_line, b_line);
        end
        n_vec++;
        if (b_vrise != 0 || n_vrise != 2) begin
            n_err++;
            $display("FAIL vsync_rise_align: %0d rises, %0d misaligned (need 2 rises at y=12 x=336)", n_vrise, b_vrise);
        end
        n_vec++;
        if (b_vfall != 0 || n_vfall != 2) begin
            n_err++;
            $display("FAIL vsync_fall_align: %0d falls, %0d misaligned (need 2 falls at y=15 x=336)", n_vfall, b_vfall);
        end
        n_vec++;
        if (b_vwidth != 0) begin
            n_err++;
            $display("FAIL vsync_width: %0d pulses not 1200 clks, last run %0d", b_vwidth, vs_run);
        end
        n_vec++;
        if (b_f2 != 0 || n_f2 != 2) begin
            n_err++;
            $display("FAIL frame_period: %0d periods, %0d not 12000 clks (need 2, 0 bad)", n_f2, b_f2);
        end
        n_vec++;
        if (b_f1 != 0 || n_f1 < 600) begin
            n_err++;
            $display("FAIL small_frame_period: %0d periods, %0d not 35 clks", n_f1, b_f1);
        end
        n_vec++;
        if (b_de != 0) begin
            n_err++;
            $display("FAIL small_de_count: %0d frames without 8 de clks, required 0", b_de);
        end
        n_vec++;
        if (xmax != 6 || ymax != 4) begin
            n_err++;
            $display("FAIL small_range: max x=%0d y=%0d expected 6 4", xmax, ymax);
        end
        n_vec++;
        if (ls_bad != base) begin
            n_err++;
            $display("FAIL lockstep_full: %0d bad cycles, dut%0d got %h expected %h", ls_bad - base, ls_dut, ls_got, ls_exp);
        end
    endtask

    task automatic test_quarter_rate();
        int          base = ls_bad;
        int          run = 0, n_pulse = 0, b_width = 0, b_chg = 0;
        bit          armed = 0;
        logic        p_hs;
        logic [11:0] p_x;
        bit          en;
        p_hs = hs[0];
        p_x  = xo[0];
        for (int c = 0; c < 4800; c++) begin
            en     = (c % 4 == 0);
            ce_pix = en;
            @(negedge clk);
            if ((xo[0] != p_x) != en) b_chg++;
            if (hs[0] && !p_hs) begin
                armed = 1;
                run   = 0;
            end
            if (hs[0]) run++;
            if (!hs[0] && p_hs && armed) begin
                n_pulse++;
                if (run != 128) b_width++;
            end
            p_hs = hs[0];
            p_x  = xo[0];
        end
        ce_pix = 1'b0;
        n_vec++;
        if (b_width != 0 || n_pulse < 2) begin
            n_err++;
            $display("FAIL hsync_width_quarter: %0d pulses, %0d not 128 clks (need >=2, 0 bad)", n_pulse, b_width);
        end
        n_vec++;
        if (b_chg != 0) begin
            n_err++;
            $display("FAIL update_timing_quarter: %0d cycles where x change disagreed with enable, required 0", b_chg);
        end
        n_vec++;
        if (ls_bad != base) begin
            n_err++;
            $display("FAIL lockstep_quarter: %0d bad cycles, dut%0d got %h expected %h", ls_bad - base, ls_dut, ls_got, ls_exp);
        end
    endtask

    task automatic test_random_ce();
        int base = ls_bad;
        for (int c = 0; c < 6000; c++) begin
            ce_pix = ($urandom_range(0, 2) != 0);
            reset  = ($urandom_range(0, 999) == 0);
            @(negedge clk);
        end
        reset  = 1'b0;
        ce_pix = 1'b0;
        n_vec++;
        if (ls_bad != base) begin
            n_err++;
            $display("FAIL lockstep_random: %0d bad cycles, dut%0d got %h expected %h", ls_bad - base, ls_dut, ls_got, ls_exp);
        end
    endtask

    task automatic test_mid_reset();
        int          base  = ls_bad;
        bit          found = 0;
        logic [30:0] rv    = {7'b0011000, 24'd0};
        reset  = 1'b0;
        ce_pix = 1'b1;
        for (int k = 0; k < 1000 && !found; k++) begin
            @(negedge clk);
            if (xo[0] == 12'd100) found = 1;
        end
        n_vec++;
        if (!found) begin
            n_err++;
            $display("FAIL reach_x100: x never reached 100 in 1000 clks, last x=%0d", xo[0]);
        end
        reset = 1'b1;
        @(negedge clk);
        n_vec++;
        if (got_vec(0) !== rv) begin
            n_err++;
            $display("FAIL mid_reset_values: got %h expected %h", got_vec(0), rv);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({xo[0], yo[0], fs[0], ls[0]} !== {24'd0, 2'b11}) begin
            n_err++;
            $display("FAIL restart_origin: x=%0d y=%0d fs=%b ls=%b expected 0 0 1 1", xo[0], yo[0], fs[0], ls[0]);
        end
        @(negedge clk);
        n_vec++;
        if ({xo[0], fs[0], ls[0]} !== {12'd1, 2'b00}) begin
            n_err++;
            $display("FAIL single_pulse: x=%0d fs=%b ls=%b expected 1 0 0", xo[0], fs[0], ls[0]);
        end
        ce_pix = 1'b0;
        n_vec++;
        if (ls_bad != base) begin
            n_err++;
            $display("FAIL lockstep_mid_reset: %0d bad cycles, dut%0d got %h expected %h", ls_bad - base, ls_dut, ls_got, ls_exp);
        end
    endtask

    initial begin
        test_reset();
        test_full_rate();
        test_quarter_rate();
        test_random_ce();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded 2 ms, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
